csi_pkt_rx: RTL and testbench
=============================

// Module: csi_pkt_rx
// PURPOSE
//   Receive side of the CSI link. Accepts the deserialized single-lane HS byte stream (one byte per clk, byte clock = 8*T_HS_CLK_UI).
//   Finds SoT sync byte, decodes the 4-byte packet header and checks its ECC. Streams long-packet payload bytes and checks payload CRC-16.
//   Sits between lane byte deserializer and pixel unpacker; pairs with the TX packet builder for loopback benches.
// PARAMETERS
//   SOT_BYTE   8'hB8   HS sync byte that starts a burst
//   MAX_WC     16'd8192 largest accepted word count (bytes); larger -> len_err, packet dropped
// PORTS
//   clk         in   1   byte clock
//   rstn        in   1   async active-low reset
//   hs_valid    in   1   lane in HS mode, hs_data valid this cycle
//   hs_data     in   8   received byte, LSB first on wire
//   hdr_vld     out  1   1-cycle pulse: header decoded
//   hdr_di      out  8   data identifier {VC[7:6],DT[5:0]}, held until next hdr_vld
//   hdr_wc      out  16  word count / short-packet data, held
//   ecc_err     out  1   with hdr_vld: received ECC != computed ECC
//   pl_valid    out  1   payload byte valid
//   pl_data     out  8   payload byte
//   pl_last     out  1   with pl_valid: final payload byte
//   crc_vld     out  1   1-cycle pulse: CRC compare done
//   crc_err     out  1   with crc_vld: mismatch
//   len_err     out  1   1-cycle pulse: WC > MAX_WC
//   trunc_err   out  1   1-cycle pulse: hs_valid fell before packet complete
//   busy        out  1   FSM not in IDLE
// BEHAVIOUR
//   Reset: FSM=IDLE; all outputs 0 (hdr_di/hdr_wc = 0). Reset mid-packet discards everything; no error pulse.
//   All outputs registered: response appears 1 clk after the hs_data byte that causes it.
//   FSM: IDLE -> HDR on hs_valid & hs_data==SOT_BYTE (other bytes in IDLE ignored).
//     HDR: capture bytes DI, WC_lo, WC_hi, ECC (count 0..3). On 4th byte: hdr_vld=1, ecc_err from check.
//       DT<=0x0F: short packet -> WAIT_EOT. Long, WC>MAX_WC -> len_err, WAIT_EOT. Long, WC==0 -> CRC. Else -> PAYLOAD.
//     PAYLOAD: 16-bit down-counter loaded with WC; each hs_valid byte -> pl_valid; pl_last on count==1 -> CRC.
//     CRC: 2 bytes, CRC_lo then CRC_hi; after 2nd byte crc_vld=1, crc_err=(rx!=calc) -> WAIT_EOT.
//     WAIT_EOT: ignore bytes (EoT trailer) until hs_valid=0 -> IDLE. One packet per HS burst.
//   hs_valid=0 while in HDR/PAYLOAD/CRC: trunc_err pulse, no crc_vld, -> IDLE same edge. pl_last never issued.
//   ECC: CSI-2 6-bit Hamming over 24-bit {WC_hi,WC_lo,DI}; ECC[7:6] expected 0. Detection only, no correction; header used as received.
//   ECC error does not abort: packet still processed per received DI/WC.
//   CRC: CRC-16 poly x^16+x^12+x^5+1, seed 0xFFFF, bytes LSB-first bitwise, no final XOR; covers payload only; reseeded at each header.
//   hdr_vld and pl_valid never in same cycle; crc_vld never with pl_valid.
// TESTING
//   Short pkt: B8,00,00,00,ECC(0x00 DI/WC) then hs_valid=0 -> hdr_vld, di=0x00, wc=0, ecc_err=0, no pl_valid, busy 0 after.
//   Long pkt DI=0x2B WC=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, CRC F0 00 -> 24 pl_valid, pl_last on 01, crc_vld, crc_err=0.
//   Same packet with CRC F1 00 -> crc_vld with crc_err=1; flip one header bit -> ecc_err=1 with hdr_vld.
//   Long pkt WC=100, drop hs_valid after 50 payload bytes -> 50 pl_valid, trunc_err pulse, no crc_vld, FSM IDLE.
//   WC=0xFFFF (> MAX_WC) -> hdr_vld + len_err, no payload; WC=0 long -> next 2 bytes CRC FF FF, crc_err=0.
//   Garbage bytes 0x00,0x47 before B8; rstn pulse mid-payload -> outputs 0 async, next burst decoded normally.

Source files
------------

// File: rtl/csi_pkt_rx_if.sv
// Byte-stream and decode-result bundle between the lane deserializer (master)
// and the CSI packet receiver (slave).
interface csi_pkt_rx_if;
  logic        hs_valid;
  logic [7:0]  hs_data;
  logic        hdr_vld;
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic        ecc_err;
  logic        pl_valid;
  logic [7:0]  pl_data;
  logic        pl_last;
  logic        crc_vld;
  logic        crc_err;
  logic        len_err;
  logic        trunc_err;
  logic        busy;

  modport master (
    output hs_valid, hs_data,
    input  hdr_vld, hdr_di, hdr_wc, ecc_err, pl_valid, pl_data, pl_last,
           crc_vld, crc_err, len_err, trunc_err, busy
  );

  modport slave (
    input  hs_valid, hs_data,
    output hdr_vld, hdr_di, hdr_wc, ecc_err, pl_valid, pl_data, pl_last,
           crc_vld, crc_err, len_err, trunc_err, busy
  );
endinterface

// File: rtl/csi_pkt_rx.sv
// CSI single-lane packet receiver: SoT detect, header decode with ECC check,
// payload streaming with CRC-16 check. All results registered.
module csi_pkt_rx #(
  parameter logic [7:0]  SOT_BYTE = 8'hB8,
  parameter logic [15:0] MAX_WC   = 16'd8192
) (
  input logic         clk,
  input logic         rstn,
  csi_pkt_rx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, WAIT_EOT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  hb0_q, hb0_d, hb1_q, hb1_d, hb2_q, hb2_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_lo_q, crc_lo_d;
  logic        hdr_vld_q, hdr_vld_d;
  logic [7:0]  hdr_di_q, hdr_di_d;
  logic [15:0] hdr_wc_q, hdr_wc_d;
  logic        ecc_err_q, ecc_err_d;
  logic        pl_valid_q, pl_valid_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic        pl_last_q, pl_last_d;
  logic        crc_vld_q, crc_vld_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;
  logic        trunc_err_q, trunc_err_d;
  logic [15:0] hdr_wc_rx;

  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Reflected CCITT form: bits enter LSB first, so the register shifts right.
  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign hdr_wc_rx = {hb2_q, hb1_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hb0_d       = hb0_q;
    hb1_d       = hb1_q;
    hb2_d       = hb2_q;
    rem_d       = rem_q;
    crc_d       = crc_q;
    crc_lo_d    = crc_lo_q;
    hdr_di_d    = hdr_di_q;
    hdr_wc_d    = hdr_wc_q;
    pl_data_d   = pl_data_q;
    hdr_vld_d   = 1'b0;
    ecc_err_d   = 1'b0;
    pl_valid_d  = 1'b0;
    pl_last_d   = 1'b0;
    crc_vld_d   = 1'b0;
    crc_err_d   = 1'b0;
    len_err_d   = 1'b0;
    trunc_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.hs_valid && bus.hs_data == SOT_BYTE) begin
          state_d = HDR;
          cnt_d   = 2'd0;
        end
      end

      HDR: begin
        if (!bus.hs_valid) begin
          trunc_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
          case (cnt_q)
            2'd0: hb0_d = bus.hs_data;
            2'd1: hb1_d = bus.hs_data;
            2'd2: hb2_d = bus.hs_data;
            2'd3: begin
              // Header is used as received even when the ECC disagrees.
              hdr_vld_d = 1'b1;
              hdr_di_d  = hb0_q;
              hdr_wc_d  = hdr_wc_rx;
              ecc_err_d = (bus.hs_data != {2'b00, calc_ecc({hb2_q, hb1_q, hb0_q})});
              crc_d     = 16'hFFFF;
              rem_d     = hdr_wc_rx;
              cnt_d     = 2'd0;
              if (hb0_q[5:0] <= 6'h0F) begin
                state_d = WAIT_EOT;
              end else if (hdr_wc_rx > MAX_WC) begin
                len_err_d = 1'b1;
                state_d   = WAIT_EOT;
              end else if (hdr_wc_rx == 16'd0) begin
                state_d = CRC;
              end else begin
                state_d = PAYLOAD;
              end
            end
            default: ;
          endcase
        end
      end

      PAYLOAD: begin
        if (!bus.hs_valid) begin
          trunc_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          pl_valid_d = 1'b1;
          pl_data_d  = bus.hs_data;
          crc_d      = crc_byte(crc_q, bus.hs_data);
          rem_d      = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            pl_last_d = 1'b1;
            cnt_d     = 2'd0;
            state_d   = CRC;
          end
        end
      end

      CRC: begin
        if (!bus.hs_valid) begin
          trunc_err_d = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == 2'd0) begin
          crc_lo_d = bus.hs_data;
          cnt_d    = 2'd1;
        end else begin
          crc_vld_d = 1'b1;
          crc_err_d = ({bus.hs_data, crc_lo_q} != crc_q);
          cnt_d     = 2'd0;
          state_d   = WAIT_EOT;
        end
      end

      WAIT_EOT: begin
        if (!bus.hs_valid) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      hb0_q       <= 8'd0;
      hb1_q       <= 8'd0;
      hb2_q       <= 8'd0;
      rem_q       <= 16'd0;
      crc_q       <= 16'hFFFF;
      crc_lo_q    <= 8'd0;
      hdr_vld_q   <= 1'b0;
      hdr_di_q    <= 8'd0;
      hdr_wc_q    <= 16'd0;
      ecc_err_q   <= 1'b0;
      pl_valid_q  <= 1'b0;
      pl_data_q   <= 8'd0;
      pl_last_q   <= 1'b0;
      crc_vld_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hb0_q       <= hb0_d;
      hb1_q       <= hb1_d;
      hb2_q       <= hb2_d;
      rem_q       <= rem_d;
      crc_q       <= crc_d;
      crc_lo_q    <= crc_lo_d;
      hdr_vld_q   <= hdr_vld_d;
      hdr_di_q    <= hdr_di_d;
      hdr_wc_q    <= hdr_wc_d;
      ecc_err_q   <= ecc_err_d;
      pl_valid_q  <= pl_valid_d;
      pl_data_q   <= pl_data_d;
      pl_last_q   <= pl_last_d;
      crc_vld_q   <= crc_vld_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign bus.hdr_vld   = hdr_vld_q;
  assign bus.hdr_di    = hdr_di_q;
  assign bus.hdr_wc    = hdr_wc_q;
  assign bus.ecc_err   = ecc_err_q;
  assign bus.pl_valid  = pl_valid_q;
  assign bus.pl_data   = pl_data_q;
  assign bus.pl_last   = pl_last_q;
  assign bus.crc_vld   = crc_vld_q;
  assign bus.crc_err   = crc_err_q;
  assign bus.len_err   = len_err_q;
  assign bus.trunc_err = trunc_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_csi_pkt_rx.sv
// Scoreboard bench for csi_pkt_rx: directed bursts push expected output events,
// a negedge monitor pops and compares each event the receiver presents.
module tb_csi_pkt_rx;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  csi_pkt_rx_if bus();

  csi_pkt_rx dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // flags: hdr_vld, ecc_err, len_err, pl_valid, pl_last, crc_vld, crc_err, trunc_err
  typedef struct packed {
    logic [7:0]  flags;
    logic [7:0]  di;
    logic [15:0] wc;
    logic [7:0]  data;
  } ev_t;

  ev_t        exp_q[$];
  int         total_count = 0;
  int         pass_count  = 0;
  logic [7:0] vec24 [24];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total_count++;
    if (act === req) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    @(posedge clk);
    #1;
    bus.hs_valid = valid;
    bus.hs_data  = data;
  endtask

  task automatic expect_hdr(input logic [7:0] di, input logic [15:0] wc, input logic ecc, input logic len);
    ev_t e;
    e       = '0;
    e.flags = {1'b1, ecc, len, 5'b0};
    e.di    = di;
    e.wc    = wc;
    exp_q.push_back(e);
  endtask

  task automatic expect_pl(input logic [7:0] data, input logic last);
    ev_t e;
    e       = '0;
    e.flags = {3'b000, 1'b1, last, 3'b000};
    e.data  = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_crc(input logic err);
    ev_t e;
    e       = '0;
    e.flags = {5'b00000, 1'b1, err, 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic expect_trunc();
    ev_t e;
    e       = '0;
    e.flags = 8'h01;
    exp_q.push_back(e);
  endtask

  task automatic send_header(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc,
                             input logic exp_ecc, input logic exp_len);
    applyStimulus(1'b1, 8'hB8);
    applyStimulus(1'b1, di);
    applyStimulus(1'b1, wc[7:0]);
    applyStimulus(1'b1, wc[15:8]);
    expect_hdr(di, wc, exp_ecc, exp_len);
    applyStimulus(1'b1, ecc);
  endtask

  task automatic end_burst();
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
  endtask

  task automatic send_vec24(input logic [7:0] di, input logic [7:0] ecc, input logic exp_ecc,
                            input logic [7:0] crc_lo, input logic [7:0] crc_hi, input logic exp_crc);
    send_header(di, 16'd24, ecc, exp_ecc, 1'b0);
    for (int i = 0; i < 24; i++) begin
      expect_pl(vec24[i], i == 23);
      applyStimulus(1'b1, vec24[i]);
    end
    applyStimulus(1'b1, crc_lo);
    expect_crc(exp_crc);
    applyStimulus(1'b1, crc_hi);
    applyStimulus(1'b1, 8'hB8);
    applyStimulus(1'b1, 8'h00);
    end_burst();
  endtask

  always @(negedge clk) begin : monitor
    ev_t obs;
    ev_t e;
    if (rstn && (bus.hdr_vld || bus.pl_valid || bus.crc_vld || bus.len_err || bus.trunc_err)) begin
      obs       = '0;
      obs.flags = {bus.hdr_vld, bus.ecc_err, bus.len_err, bus.pl_valid, bus.pl_last,
                   bus.crc_vld, bus.crc_err, bus.trunc_err};
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", {24'd0, obs.flags}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_flags", {24'd0, obs.flags}, {24'd0, e.flags});
        if (e.flags[7]) begin
          checkOutput("hdr_di", {24'd0, bus.hdr_di}, {24'd0, e.di});
          checkOutput("hdr_wc", {16'd0, bus.hdr_wc}, {16'd0, e.wc});
        end
        if (e.flags[4]) checkOutput("pl_data", {24'd0, bus.pl_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec24 = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
              8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
              8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    rstn         = 1'b0;
    bus.hs_valid = 1'b0;
    bus.hs_data  = 8'h00;

    #23;
    checkOutput("reset_busy",     {31'd0, bus.busy},     32'd0);
    checkOutput("reset_hdr_vld",  {31'd0, bus.hdr_vld},  32'd0);
    checkOutput("reset_hdr_di",   {24'd0, bus.hdr_di},   32'd0);
    checkOutput("reset_hdr_wc",   {16'd0, bus.hdr_wc},   32'd0);
    checkOutput("reset_pl_valid", {31'd0, bus.pl_valid}, 32'd0);
    checkOutput("reset_crc_vld",  {31'd0, bus.crc_vld},  32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    end_burst();

    // Short packet, all-zero header.
    send_header(8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);
    end_burst();
    checkOutput("short_busy_after", {31'd0, bus.busy}, 32'd0);

    // Garbage before SoT, then the reference long packet.
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h47);
    send_vec24(8'h2B, 8'h14, 1'b0, 8'hF0, 8'h00, 1'b0);
    checkOutput("hdr_di_held", {24'd0, bus.hdr_di}, 32'h2B);
    checkOutput("hdr_wc_held", {16'd0, bus.hdr_wc}, 32'd24);

    // Corrupted CRC, then a flipped DI bit under the original ECC.
    send_vec24(8'h2B, 8'h14, 1'b0, 8'hF1, 8'h00, 1'b1);
    send_vec24(8'h2A, 8'h14, 1'b1, 8'hF0, 8'h00, 1'b0);

    // Truncated long packet: 50 of 100 payload bytes.
    send_header(8'h2B, 16'd100, 8'h37, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      expect_pl(8'(i * 3 + 1), 1'b0);
      applyStimulus(1'b1, 8'(i * 3 + 1));
    end
    expect_trunc();
    end_burst();
    checkOutput("trunc_busy_after", {31'd0, bus.busy}, 32'd0);

    // Oversized word count.
    send_header(8'h2B, 16'hFFFF, 8'h2D, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    end_burst();
    checkOutput("len_busy_after", {31'd0, bus.busy}, 32'd0);

    // Zero-length long packet: CRC is the untouched seed.
    send_header(8'h2B, 16'h0000, 8'h17, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF);
    expect_crc(1'b0);
    applyStimulus(1'b1, 8'hFF);
    end_burst();

    // Reset in the middle of a payload.
    send_header(8'h2B, 16'd24, 8'h14, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      expect_pl(vec24[i], 1'b0);
      applyStimulus(1'b1, vec24[i]);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    rstn         = 1'b0;
    bus.hs_valid = 1'b0;
    #1;
    checkOutput("midrst_busy",     {31'd0, bus.busy},     32'd0);
    checkOutput("midrst_pl_valid", {31'd0, bus.pl_valid}, 32'd0);
    checkOutput("midrst_hdr_di",   {24'd0, bus.hdr_di},   32'd0);
    checkOutput("midrst_hdr_wc",   {16'd0, bus.hdr_wc},   32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    end_burst();

    send_header(8'h01, 16'h0000, 8'h07, 1'b0, 1'b0);
    end_burst();
    checkOutput("post_reset_busy", {31'd0, bus.busy}, 32'd0);

    repeat (5) applyStimulus(1'b0, 8'h00);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
